// File: rtl/lif_pkg.sv
// lif_pkg: shared types and arithmetic helpers for the LIF neuron cluster.
//   lif_state_e  - sweep controller states
//   CFG_*        - cfg_sel codes
//   sat_add      - signed add saturated to a w-bit signed range
//   leak_toward_zero / leak_shift - the two leak laws
// Helpers operate on a wide signed type; callers sign-extend in and truncate out.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SWEEP      = 2'd1,
    ST_DRAIN_WAIT = 2'd2,
    ST_DONE       = 2'd3
  } lif_state_e;

  localparam logic [1:0] CFG_POT    = 2'd0;
  localparam logic [1:0] CFG_REFRAC = 2'd1;
  localparam logic [1:0] CFG_THRESH = 2'd2;
  localparam logic [1:0] CFG_RSVD   = 2'd3;

  localparam int unsigned LIF_CALC_W = 64;
  typedef logic signed [LIF_CALC_W-1:0] lif_calc_t;

  function automatic lif_calc_t sat_add(input lif_calc_t a, input lif_calc_t b,
                                        input int unsigned w);
    lif_calc_t sum, hi, lo;
    sum = a + b;
    hi  = (lif_calc_t'(1) <<< (w - 1)) - lif_calc_t'(1);
    lo  = -hi - lif_calc_t'(1);
    if (sum > hi)      sat_add = hi;
    else if (sum < lo) sat_add = lo;
    else               sat_add = sum;
  endfunction

  // Move v toward zero by mag without crossing zero.
  function automatic lif_calc_t leak_toward_zero(input lif_calc_t v, input lif_calc_t mag);
    lif_calc_t r;
    r = '0;
    if (v > 0) begin
      r = v - mag;
      if (r < 0) r = '0;
    end else if (v < 0) begin
      r = v + mag;
      if (r > 0) r = '0;
    end
    leak_toward_zero = r;
  endfunction

  function automatic lif_calc_t leak_shift(input lif_calc_t v, input logic [3:0] sh);
    leak_shift = v - (v >>> sh);
  endfunction

endpackage

// File: rtl/lif_neuron_cluster_spike_fifo.sv
// spike_fifo: synchronous valid/ready FIFO (DEPTH a power of 2, >= 2).
//   in_valid_i/in_ready_o/in_data_i   - write side; accepts when full if a pop happens
//   out_ready_i/out_data_o            - read side; valid is !empty_o, data held until popped
//   full_o/empty_o                    - occupancy flags
// rst empties the FIFO; out_data_o reads 0 while empty.
module spike_fifo
  import lif_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop        = !empty_o && out_ready_i;
  assign in_ready_o = !full_o || out_ready_i;
  assign push       = in_valid_i && in_ready_o;
  assign out_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/lif_neuron_cluster.sv
// lif_neuron_cluster: NUM_NEURONS leaky integrate-and-fire neurons, time-multiplexed.
//   s_spike_*   - weighted input spike, integrated in one cycle while IDLE
//   tick_*      - timestep request; sweeps every neuron once (leak/fire/refractory)
//   m_spike_*   - fired neuron ids, ascending within a tick, via spike_fifo
//   cfg_*       - per-neuron potential/refractory/threshold write; cfg_err pulses on reject
//   leak_value, refrac_period - global neuron parameters
//   busy        - controller not IDLE
// Optional: define LIF_SPIKE_STATS_EN to add spike_total (wrapping push count) and
// stall_cycles (saturating DRAIN_WAIT cycle count).
module lif_neuron_cluster
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS     = 64,
  parameter int DATA_WIDTH      = 16,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int REFRAC_WIDTH    = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int LEAK_MODE       = 0,
  parameter int RESET_MODE      = 0,
  parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_spike_valid,
  output logic                       s_spike_ready,
  input  logic [NEURON_ID_WIDTH-1:0] s_spike_id,
  input  logic [WEIGHT_WIDTH-1:0]    s_spike_weight,
  input  logic                       tick_valid,
  output logic                       tick_ready,
  output logic                       tick_done,
  output logic                       m_spike_valid,
  input  logic                       m_spike_ready,
  output logic [NEURON_ID_WIDTH-1:0] m_spike_id,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [NEURON_ID_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0]      cfg_wdata,
  output logic                       cfg_err,
  input  logic [DATA_WIDTH-1:0]      leak_value,
  input  logic [REFRAC_WIDTH-1:0]    refrac_period,
  output logic                       busy
`ifdef LIF_SPIKE_STATS_EN
  ,
  output logic [31:0]                spike_total,
  output logic [31:0]                stall_cycles
`endif
);

  typedef logic signed [DATA_WIDTH-1:0] pot_t;

  localparam logic [NEURON_ID_WIDTH:0]   NUM_N    = (NEURON_ID_WIDTH+1)'(NUM_NEURONS);
  localparam logic [NEURON_ID_WIDTH-1:0] LAST_IDX = NEURON_ID_WIDTH'(NUM_NEURONS - 1);
  localparam pot_t                       THR_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  pot_t                    v_q   [NUM_NEURONS];
  pot_t                    thr_q [NUM_NEURONS];
  logic [REFRAC_WIDTH-1:0] ref_q [NUM_NEURONS];

  lif_state_e                 state_q, state_d;
  logic [NEURON_ID_WIDTH-1:0] idx_q, idx_d;
  logic                       cfg_err_q;

  logic                    idle, cfg_ok, spk_hit, fire, sweep_adv;
  logic                    fifo_in_ready, fifo_full, fifo_empty;
  pot_t                    spk_sum, cur_v, cur_thr, leaked, after_fire;
  logic [REFRAC_WIDTH-1:0] cur_ref;

  assign idle          = (state_q == ST_IDLE);
  assign s_spike_ready = idle;
  assign tick_ready    = idle;
  assign busy          = !idle;
  assign cfg_err       = cfg_err_q;
  assign m_spike_valid = !fifo_empty;

  always_comb begin
    cfg_ok = cfg_we && idle && (cfg_sel != CFG_RSVD) && ({1'b0, cfg_addr} < NUM_N);
    // A config write to the same neuron takes precedence; the spike is still consumed.
    spk_hit = s_spike_valid && idle && ({1'b0, s_spike_id} < NUM_N)
              && !(cfg_ok && (cfg_addr == s_spike_id))
              && (ref_q[s_spike_id] == '0);
    spk_sum = pot_t'(sat_add(lif_calc_t'(v_q[s_spike_id]),
                             lif_calc_t'($signed(s_spike_weight)), DATA_WIDTH));

    cur_v   = v_q[idx_q];
    cur_thr = thr_q[idx_q];
    cur_ref = ref_q[idx_q];
    if (LEAK_MODE == 1)
      leaked = pot_t'(leak_shift(lif_calc_t'(cur_v), leak_value[3:0]));
    else
      leaked = pot_t'(leak_toward_zero(lif_calc_t'(cur_v), lif_calc_t'({1'b0, leak_value})));
    if (RESET_MODE == 1)
      after_fire = pot_t'(sat_add(lif_calc_t'(leaked), -lif_calc_t'(cur_thr), DATA_WIDTH));
    else
      after_fire = '0;

    fire      = (state_q == ST_SWEEP) && (cur_ref == '0) && (leaked >= cur_thr);
    // A firing neuron is only committed once its id can enter the FIFO.
    sweep_adv = (state_q == ST_SWEEP) && (!fire || fifo_in_ready);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tick_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_valid) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (!sweep_adv)             state_d = ST_DRAIN_WAIT;
        else if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                        idx_d   = idx_q + NEURON_ID_WIDTH'(1);
      end
      ST_DRAIN_WAIT: begin
        if (!fifo_full) state_d = ST_SWEEP;
      end
      ST_DONE: begin
        tick_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_err_q <= cfg_we && !cfg_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]   <= '0;
        thr_q[i] <= THR_MAX;
        ref_q[i] <= '0;
      end
    end else begin
      if (spk_hit) v_q[s_spike_id] <= spk_sum;
      if (cfg_ok) begin
        case (cfg_sel)
          CFG_POT:    v_q[cfg_addr]   <= cfg_wdata;
          CFG_REFRAC: ref_q[cfg_addr] <= cfg_wdata[REFRAC_WIDTH-1:0];
          CFG_THRESH: thr_q[cfg_addr] <= cfg_wdata;
          default:    ;
        endcase
      end
      if (sweep_adv) begin
        if (cur_ref != '0) begin
          ref_q[idx_q] <= cur_ref - REFRAC_WIDTH'(1);
        end else if (fire) begin
          v_q[idx_q]   <= after_fire;
          ref_q[idx_q] <= refrac_period;
        end else begin
          v_q[idx_q]   <= leaked;
        end
      end
    end
  end

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NEURON_ID_WIDTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (fire),
    .in_ready_o  (fifo_in_ready),
    .in_data_i   (idx_q),
    .out_ready_i (m_spike_ready),
    .out_data_o  (m_spike_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef LIF_SPIKE_STATS_EN
  logic [31:0] spike_total_q, stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_total_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (fire && fifo_in_ready) spike_total_q <= spike_total_q + 32'd1;
      if ((state_q == ST_DRAIN_WAIT) && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign spike_total  = spike_total_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_lif_neuron_cluster.sv
// Directed testbench for lif_neuron_cluster (8 neurons, 4-entry FIFO, 16-bit potentials).
module tb_lif_neuron_cluster;

  localparam logic [1:0] SEL_POT = 2'd0, SEL_REF = 2'd1, SEL_THR = 2'd2, SEL_RSV = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_spike_valid, s_spike_ready;
  logic [2:0]  s_spike_id;
  logic [7:0]  s_spike_weight;
  logic        tick_valid, tick_ready, tick_done;
  logic        m_spike_valid, m_spike_ready;
  logic [2:0]  m_spike_id;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_err;
  logic [15:0] leak_value;
  logic [7:0]  refrac_period;
  logic        busy;
`ifdef LIF_SPIKE_STATS_EN
  logic [31:0] spike_total, stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;
  int got[$];

  lif_neuron_cluster #(
    .NUM_NEURONS (8),
    .DATA_WIDTH  (16),
    .WEIGHT_WIDTH(8),
    .REFRAC_WIDTH(8),
    .FIFO_DEPTH  (4),
    .LEAK_MODE   (0),
    .RESET_MODE  (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_spike_valid (s_spike_valid),
    .s_spike_ready (s_spike_ready),
    .s_spike_id    (s_spike_id),
    .s_spike_weight(s_spike_weight),
    .tick_valid    (tick_valid),
    .tick_ready    (tick_ready),
    .tick_done     (tick_done),
    .m_spike_valid (m_spike_valid),
    .m_spike_ready (m_spike_ready),
    .m_spike_id    (m_spike_id),
    .cfg_we        (cfg_we),
    .cfg_sel       (cfg_sel),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_err       (cfg_err),
    .leak_value    (leak_value),
    .refrac_period (refrac_period),
    .busy          (busy)
`ifdef LIF_SPIKE_STATS_EN
    ,
    .spike_total   (spike_total),
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    s_spike_valid = 1'b0; s_spike_id = '0; s_spike_weight = '0;
    tick_valid = 1'b0; m_spike_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    leak_value = '0; refrac_period = 8'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_spike(input logic [2:0] id, input logic [7:0] w);
    @(negedge clk);
    s_spike_valid = 1'b1; s_spike_id = id; s_spike_weight = w;
    @(negedge clk);
    s_spike_valid = 1'b0;
  endtask

  // Issues one tick (optionally with a simultaneous spike), collects output ids in got[].
  task automatic run_tick(input bit with_spk, input logic [2:0] id, input logic [7:0] w,
                          output int cycles);
    bit done;
    done = 1'b0;
    cycles = 0;
    got.delete();
    @(negedge clk);
    tick_valid = 1'b1;
    if (with_spk) begin
      s_spike_valid = 1'b1; s_spike_id = id; s_spike_weight = w;
    end
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      tick_valid = 1'b0;
      s_spike_valid = 1'b0;
      if (m_spike_valid && m_spike_ready) got.push_back(int'(m_spike_id));
      if (tick_done) done = 1'b1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL tick_timeout: got no tick_done within %0d cycles, required tick_done", cycles);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!m_spike_valid) break;
      got.push_back(int'(m_spike_id));
    end
  endtask

  task automatic set_all_firing();
    for (int i = 0; i < 8; i++) begin
      cfg_write(SEL_THR, 3'(i), 16'd0);
      cfg_write(SEL_POT, 3'(i), 16'd1);
    end
  endtask

  task automatic test_reset();
    bit bad;
    apply_reset();
    vectors++;
    if ({tick_ready, s_spike_ready, busy, m_spike_valid, tick_done, cfg_err} !== 6'b110000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 110000",
               {tick_ready, s_spike_ready, busy, m_spike_valid, tick_done, cfg_err});
    end
    vectors++;
    if (m_spike_id !== 3'd0) begin
      miscompares++; $display("FAIL reset_m_id: got %0d required 0", m_spike_id);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++)
      if (dut.v_q[i] !== 16'sd0 || dut.ref_q[i] !== 8'd0 || dut.thr_q[i] !== 16'sh7FFF) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL reset_state: got non-reset neuron state, required v=0 ref=0 thr=32767");
    end
  endtask

  task automatic test_integrate_fire();
    int cyc;
    apply_reset();
    refrac_period = 8'd3;
    cfg_write(SEL_THR, 3'd3, 16'd100);
    repeat (3) send_spike(3'd3, 8'd40);
    vectors++;
    if (dut.v_q[3] !== 16'sd120) begin
      miscompares++; $display("FAIL integrate_v3: got %0d required 120", dut.v_q[3]);
    end
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (got.size() != 1 || got[0] != 3) begin
      miscompares++; $display("FAIL fire_ids: got %0d ids (first %0d) required one id 3",
                              got.size(), (got.size() > 0) ? got[0] : -1);
    end
    vectors++;
    if (cyc != 9) begin
      miscompares++; $display("FAIL sweep_latency: got %0d cycles required 9", cyc);
    end
    vectors++;
    if (dut.v_q[3] !== 16'sd0 || dut.ref_q[3] !== 8'd3) begin
      miscompares++; $display("FAIL fire_reset: got v=%0d ref=%0d required v=0 ref=3",
                              dut.v_q[3], dut.ref_q[3]);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cfg_write(SEL_POT, 3'd5, 16'd32760);
    send_spike(3'd5, 8'd100);
    vectors++;
    if (dut.v_q[5] !== 16'sd32767) begin
      miscompares++; $display("FAIL sat_pos: got %0d required 32767", dut.v_q[5]);
    end
    send_spike(3'd5, 8'h9C);
    vectors++;
    if (dut.v_q[5] !== 16'sd32667) begin
      miscompares++; $display("FAIL sat_nosat: got %0d required 32667", dut.v_q[5]);
    end
    cfg_write(SEL_POT, 3'd6, 16'h8008);
    send_spike(3'd6, 8'h9C);
    vectors++;
    if (dut.v_q[6] !== -16'sd32768) begin
      miscompares++; $display("FAIL sat_neg: got %0d required -32768", dut.v_q[6]);
    end
  endtask

  task automatic test_refractory();
    int cyc;
    apply_reset();
    refrac_period = 8'd2;
    cfg_write(SEL_THR, 3'd0, 16'd10);
    send_spike(3'd0, 8'd20);
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (got.size() != 1 || dut.ref_q[0] !== 8'd2) begin
      miscompares++; $display("FAIL refrac_fire: got %0d ids ref=%0d required 1 id ref=2",
                              got.size(), dut.ref_q[0]);
    end
    send_spike(3'd0, 8'd50);
    vectors++;
    if (dut.v_q[0] !== 16'sd0) begin
      miscompares++; $display("FAIL refrac_ignore: got %0d required 0", dut.v_q[0]);
    end
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (got.size() != 0 || dut.ref_q[0] !== 8'd1) begin
      miscompares++; $display("FAIL refrac_dec1: got %0d ids ref=%0d required 0 ids ref=1",
                              got.size(), dut.ref_q[0]);
    end
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (dut.ref_q[0] !== 8'd0) begin
      miscompares++; $display("FAIL refrac_dec0: got %0d required 0", dut.ref_q[0]);
    end
    send_spike(3'd0, 8'd15);
    vectors++;
    if (dut.v_q[0] !== 16'sd15) begin
      miscompares++; $display("FAIL refrac_resume: got %0d required 15", dut.v_q[0]);
    end
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (got.size() != 1 || got[0] != 0) begin
      miscompares++; $display("FAIL refrac_refire: got %0d ids required one id 0", got.size());
    end
  endtask

  task automatic test_backpressure();
    bit tick_seen, bad;
    apply_reset();
    refrac_period = 8'd5;
    set_all_firing();
    m_spike_ready = 1'b0;
    tick_seen = 1'b0;
    @(negedge clk);
    tick_valid = 1'b1;
    @(negedge clk);
    tick_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tick_done) tick_seen = 1'b1;
    end
    vectors++;
    if (busy !== 1'b1 || tick_seen || dut.idx_q !== 3'd4) begin
      miscompares++; $display("FAIL stall_idx: got busy=%b done=%b idx=%0d required busy=1 done=0 idx=4",
                              busy, tick_seen, dut.idx_q);
    end
    vectors++;
    if (m_spike_valid !== 1'b1 || m_spike_id !== 3'd0) begin
      miscompares++; $display("FAIL stall_head: got valid=%b id=%0d required valid=1 id=0",
                              m_spike_valid, m_spike_id);
    end
    m_spike_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 100; k++) begin
      if (m_spike_valid) got.push_back(int'(m_spike_id));
      if (tick_done) tick_seen = 1'b1;
      if (tick_seen && !m_spike_valid) break;
      @(negedge clk);
    end
    bad = (got.size() != 8);
    for (int i = 0; i < got.size() && i < 8; i++) if (got[i] != i) bad = 1'b1;
    vectors++;
    if (bad || !tick_seen) begin
      miscompares++; $display("FAIL drain_order: got %0d ids done=%b required ids 0..7 in order and tick_done",
                              got.size(), tick_seen);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) if (dut.v_q[i] !== 16'sd0 || dut.ref_q[i] !== 8'd5) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++; $display("FAIL drain_state: got neuron state mismatch, required v=0 ref=5 for all");
    end
  endtask

  task automatic test_leak();
    int cyc;
    apply_reset();
    leak_value = 16'd10;
    cfg_write(SEL_POT, 3'd1, 16'd5);
    cfg_write(SEL_POT, 3'd2, 16'hFFFB);
    cfg_write(SEL_POT, 3'd4, 16'hFFE2);
    cfg_write(SEL_POT, 3'd7, 16'd25);
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (dut.v_q[1] !== 16'sd0 || dut.v_q[2] !== 16'sd0) begin
      miscompares++; $display("FAIL leak_clamp: got v1=%0d v2=%0d required 0 0", dut.v_q[1], dut.v_q[2]);
    end
    vectors++;
    if (dut.v_q[4] !== -16'sd20 || dut.v_q[7] !== 16'sd15 || got.size() != 0) begin
      miscompares++; $display("FAIL leak_step: got v4=%0d v7=%0d ids=%0d required -20 15 0",
                              dut.v_q[4], dut.v_q[7], got.size());
    end
    leak_value = 16'd0;
  endtask

  task automatic test_cfg_err();
    bit done;
    apply_reset();
    @(negedge clk);
    tick_valid = 1'b1;
    @(negedge clk);
    tick_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = SEL_POT; cfg_addr = 3'd2; cfg_wdata = 16'd77;
    @(negedge clk);
    cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL cfg_busy_err: got err=%b busy=%b required 1 1", cfg_err, busy);
    end
    @(negedge clk);
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL cfg_err_pulse: got %b required 0", cfg_err);
    end
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (tick_done) done = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!done || dut.v_q[2] !== 16'sd0) begin
      miscompares++; $display("FAIL cfg_busy_nowrite: got done=%b v2=%0d required 1 0", done, dut.v_q[2]);
    end
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = SEL_RSV; cfg_addr = 3'd1; cfg_wdata = 16'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++; $display("FAIL cfg_rsvd_err: got %b required 1", cfg_err);
    end
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = SEL_POT; cfg_addr = 3'd1; cfg_wdata = 16'd5;
    @(negedge clk);
    cfg_we = 1'b0;
    vectors++;
    if (cfg_err !== 1'b0 || dut.v_q[1] !== 16'sd5) begin
      miscompares++; $display("FAIL cfg_ok: got err=%b v1=%0d required 0 5", cfg_err, dut.v_q[1]);
    end
  endtask

  task automatic test_cfg_collision();
    apply_reset();
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = SEL_POT; cfg_addr = 3'd3; cfg_wdata = 16'd50;
    s_spike_valid = 1'b1; s_spike_id = 3'd3; s_spike_weight = 8'd20;
    @(negedge clk);
    cfg_we = 1'b0; s_spike_valid = 1'b0;
    vectors++;
    if (dut.v_q[3] !== 16'sd50) begin
      miscompares++; $display("FAIL cfg_wins: got %0d required 50", dut.v_q[3]);
    end
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = SEL_POT; cfg_addr = 3'd3; cfg_wdata = 16'd7;
    s_spike_valid = 1'b1; s_spike_id = 3'd4; s_spike_weight = 8'd9;
    @(negedge clk);
    cfg_we = 1'b0; s_spike_valid = 1'b0;
    vectors++;
    if (dut.v_q[3] !== 16'sd7 || dut.v_q[4] !== 16'sd9) begin
      miscompares++; $display("FAIL cfg_spike_both: got v3=%0d v4=%0d required 7 9", dut.v_q[3], dut.v_q[4]);
    end
  endtask

  task automatic test_spike_tick_same_cycle();
    int cyc;
    apply_reset();
    cfg_write(SEL_THR, 3'd2, 16'd30);
    run_tick(1'b1, 3'd2, 8'd40, cyc);
    vectors++;
    if (got.size() != 1 || got[0] != 2 || dut.v_q[2] !== 16'sd0) begin
      miscompares++; $display("FAIL spike_tick: got %0d ids v2=%0d required one id 2 v2=0",
                              got.size(), dut.v_q[2]);
    end
  endtask

  task automatic test_rst_mid_sweep();
    int cyc;
    apply_reset();
    set_all_firing();
    m_spike_ready = 1'b0;
    @(negedge clk);
    tick_valid = 1'b1;
    @(negedge clk);
    tick_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || m_spike_valid !== 1'b0 || tick_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid: got busy=%b valid=%b tick_ready=%b required 0 0 1",
                              busy, m_spike_valid, tick_ready);
    end
    rst = 1'b0;
    m_spike_ready = 1'b1;
    run_tick(1'b0, '0, '0, cyc);
    vectors++;
    if (got.size() != 0) begin
      miscompares++; $display("FAIL rst_clean: got %0d ids required 0", got.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    s_spike_valid = 1'b0; s_spike_id = '0; s_spike_weight = '0;
    tick_valid = 1'b0; m_spike_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    leak_value = '0; refrac_period = '0;
    test_reset();
    test_integrate_fire();
    test_saturation();
    test_refractory();
    test_backpressure();
    test_leak();
    test_cfg_err();
    test_cfg_collision();
    test_spike_tick_same_cycle();
    test_rst_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
